uvmt_apb_adv_timer_pwm_meas: RTL
================================

Name: uvmt_apb_adv_timer_pwm_meas

Overview:
- Bench-side measurement stage sitting directly downstream of the APB advanced timer DUT.
- Samples one timer PWM output bit (taken from the probe interface) and measures period and high-time in clock cycles per PWM cycle.
- Detects a stuck output.
- Hands each result record to the DUT checker over a valid/ready handshake; the checker compares records against the APB-programmed threshold configuration.

Parameters:
- CNT_W, 16: width of period/high-time counters and result fields.
- TIMEOUT, 1024: cycles without a rising edge before a stuck record is emitted; must satisfy 2 <= TIMEOUT <= 2^CNT_W-1.

Ports:
- clk  input  1  bench clock (same clock as the timer DUT).
- reset  input  1  synchronous active-high reset.
- enable  input  1  measurement enable.
- pwm_i  input  1  timer PWM output under measurement.
- clr_i  input  1  clears the sticky overflow flag.
- meas_valid  output  1  result record available.
- meas_ready  input  1  consumer accepts record.
- meas_period  output  CNT_W  cycles between consecutive rising edges.
- meas_high  output  CNT_W  cycles pwm sampled high within that period.
- meas_sat  output  1  period counter saturated during this record.
- meas_stuck  output  1  record is a timeout record.
- meas_level  output  1  pwm level at timeout (stuck records only; 0 otherwise).
- meas_ovf  output  1  sticky: a record was dropped.

Behaviour:
- One clock. Reset is synchronous and active-high.
- While reset is high, all outputs are 0, the FSM is in IDLE, and counters and the pwm history flop are 0.
- pwm_s is the sampled input: pwm_i directly (see Optional Feature). rise = pwm_s & ~pwm_q, where pwm_q is pwm_s registered.
- FSM states:
  - IDLE: counters held at 0. If enable=1, go to ARM next cycle.
  - ARM: wait for rise. On rise, go to MEASURE with period_cnt=1, high_cnt=1, idle_cnt=0.
  - MEASURE, cycle without rise: period_cnt+1; high_cnt+1 if pwm_s=1; both saturate at 2^CNT_W-1.
  - MEASURE, cycle with rise: emit record {period_cnt, high_cnt, sat}; counters restart at 1; remain in MEASURE.
- Record timing: records are registered. meas_valid rises the cycle after the rise sample.
  - Example: period 10, high 5 gives meas_period=10, meas_high=5.
- meas_sat is set if period_cnt reached 2^CNT_W-1 during the record. Counters stay saturated until the next rise.
- Stuck detection:
  - In ARM and MEASURE, idle_cnt increments every cycle and clears on rise.
  - When idle_cnt == TIMEOUT-1, emit a stuck record {period=0, high=0, stuck=1, level=pwm_s}, clear idle_cnt, and go to ARM.
  - A constant input therefore yields a stuck record every TIMEOUT cycles.
  - If rise and timeout fall in the same cycle, rise wins: normal record, no stuck record.
- Handshake:
  - Single-entry output register.
  - A record transfers on meas_valid & meas_ready, after which meas_valid drops unless a new record loads in the same cycle.
  - All meas_* data fields are stable while meas_valid=1 and meas_ready=0.
  - New record and (meas_valid=0 or meas_ready=1): the new record loads.
  - New record and meas_valid=1 and meas_ready=0: the new record is dropped and meas_ovf is set.
  - meas_ovf clears only on clr_i or reset. If clr_i and a drop occur in the same cycle, set wins.
- enable deasserted: FSM goes to IDLE next cycle and any in-progress measurement is discarded without a record. A pending output record is retained until accepted.
- enable re-asserted: a fresh ARM phase; the first partial cycle is never reported.
- meas_ready is ignored while meas_valid=0.

Optional Feature:
- Macro: UVMT_APB_ADV_TIMER_PWM_MEAS_SYNC_EN.
- Defined: pwm_i passes through a 2-flop synchronizer (reset to 0) before becoming pwm_s, adding 2 cycles of latency to every record. Measured values are unchanged for steady PWM.
- Undefined: pwm_s = pwm_i, with no added latency.

Test Plan:
- enable=1, PWM period 10 with high 4, meas_ready=1 → each record is period=10, high=4, sat=0, stuck=0. The first record appears one cycle after the second rising edge.
- pwm_i held 1 after one rising edge, TIMEOUT=1024 → stuck record with level=1, period=0, high=0, followed by another stuck record every 1024 cycles.
- meas_ready=0 across three PWM periods of 8 → first record held stable and meas_ovf=1. After meas_ready=1 and clr_i, meas_ovf=0 and the next record is period=8.
- CNT_W=4, PWM period 20 with high 3 → period=15, high=3, sat=1.
- enable dropped mid-period then restored → no record from the aborted period; the first record after restore follows two rising edges.
- reset asserted mid-MEASURE with meas_valid=1 → all outputs 0 on the next cycle, FSM in IDLE, meas_ovf=0.

Source files
------------

// File: rtl/uvmt_apb_adv_timer_pwm_meas.sv
// uvmt_apb_adv_timer_pwm_meas
// Measures period and high-time of one timer PWM output bit, flags a stuck
// output after TIMEOUT cycles without a rising edge, and presents each result
// as a single registered record over a valid/ready handshake.
// Optional build macro: UVMT_APB_ADV_TIMER_PWM_MEAS_SYNC_EN
//   defined   -> pwm_i passes through a 2-flop synchronizer (2 cycles latency)
//   undefined -> pwm_i is used directly
module uvmt_apb_adv_timer_pwm_meas #(
   parameter int CNT_W   = 16,
   parameter int TIMEOUT = 1024
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             enable,
   input  logic             pwm_i,
   input  logic             clr_i,
   output logic             meas_valid,
   input  logic             meas_ready,
   output logic [CNT_W-1:0] meas_period,
   output logic [CNT_W-1:0] meas_high,
   output logic             meas_sat,
   output logic             meas_stuck,
   output logic             meas_level,
   output logic             meas_ovf
);

   localparam logic [CNT_W-1:0] CNT_MAX = '1;
   localparam int IDLE_W = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
   localparam logic [IDLE_W-1:0] IDLE_LAST = IDLE_W'(TIMEOUT - 1);

   typedef enum logic [1:0] {
      IDLE,
      ARM,
      MEASURE
   } state_t;

   state_t            state;
   logic              pwm_s;
   logic              pwm_q;
   logic              rise;
   logic              timeout_hit;
   logic [CNT_W-1:0]  period_cnt;
   logic [CNT_W-1:0]  high_cnt;
   logic [IDLE_W-1:0] idle_cnt;

   logic              rec_new;
   logic [CNT_W-1:0]  rec_period;
   logic [CNT_W-1:0]  rec_high;
   logic              rec_sat;
   logic              rec_stuck;
   logic              rec_level;

`ifdef UVMT_APB_ADV_TIMER_PWM_MEAS_SYNC_EN
   logic sync_1;
   logic sync_2;

   // Two-flop synchronizer bringing the PWM bit into the bench clock domain
   always_ff @(posedge clk) begin
      if (reset) begin
         sync_1 <= 1'b0;
         sync_2 <= 1'b0;
      end else begin
         sync_1 <= pwm_i;
         sync_2 <= sync_1;
      end
   end

   assign pwm_s = sync_2;
`else
   assign pwm_s = pwm_i;
`endif

   // History flop used for rising-edge detection; runs in every state
   always_ff @(posedge clk) begin
      if (reset) begin
         pwm_q <= 1'b0;
      end else begin
         pwm_q <= pwm_s;
      end
   end

   assign rise        = pwm_s & ~pwm_q;
   assign timeout_hit = (idle_cnt == IDLE_LAST);

   // Build the candidate record; a rise always beats a simultaneous timeout
   always_comb begin
      rec_new    = 1'b0;
      rec_period = '0;
      rec_high   = '0;
      rec_sat    = 1'b0;
      rec_stuck  = 1'b0;
      rec_level  = 1'b0;
      if (enable && (state != IDLE)) begin
         if (rise) begin
            if (state == MEASURE) begin
               rec_new    = 1'b1;
               rec_period = period_cnt;
               rec_high   = high_cnt;
               rec_sat    = (period_cnt == CNT_MAX);
            end
         end else if (timeout_hit) begin
            rec_new   = 1'b1;
            rec_stuck = 1'b1;
            rec_level = pwm_s;
         end
      end
   end

   // Measurement FSM with its period, high-time and idle counters
   always_ff @(posedge clk) begin
      if (reset || !enable) begin
         state      <= IDLE;
         period_cnt <= '0;
         high_cnt   <= '0;
         idle_cnt   <= '0;
      end else begin
         case (state)
            IDLE: begin
               state      <= ARM;
               period_cnt <= '0;
               high_cnt   <= '0;
               idle_cnt   <= '0;
            end
            ARM: begin
               if (rise) begin
                  state      <= MEASURE;
                  period_cnt <= CNT_W'(1);
                  high_cnt   <= CNT_W'(1);
                  idle_cnt   <= '0;
               end else if (timeout_hit) begin
                  idle_cnt <= '0;
               end else begin
                  idle_cnt <= idle_cnt + IDLE_W'(1);
               end
            end
            MEASURE: begin
               if (rise) begin
                  period_cnt <= CNT_W'(1);
                  high_cnt   <= CNT_W'(1);
                  idle_cnt   <= '0;
               end else if (timeout_hit) begin
                  state      <= ARM;
                  period_cnt <= '0;
                  high_cnt   <= '0;
                  idle_cnt   <= '0;
               end else begin
                  if (period_cnt != CNT_MAX) begin
                     period_cnt <= period_cnt + CNT_W'(1);
                  end
                  if (pwm_s && (high_cnt != CNT_MAX)) begin
                     high_cnt <= high_cnt + CNT_W'(1);
                  end
                  idle_cnt <= idle_cnt + IDLE_W'(1);
               end
            end
            default: begin
               state      <= IDLE;
               period_cnt <= '0;
               high_cnt   <= '0;
               idle_cnt   <= '0;
            end
         endcase
      end
   end

   // Single-entry output register; a record arriving while one is stalled is dropped
   always_ff @(posedge clk) begin
      if (reset) begin
         meas_valid  <= 1'b0;
         meas_period <= '0;
         meas_high   <= '0;
         meas_sat    <= 1'b0;
         meas_stuck  <= 1'b0;
         meas_level  <= 1'b0;
         meas_ovf    <= 1'b0;
      end else begin
         if (rec_new && (!meas_valid || meas_ready)) begin
            meas_valid  <= 1'b1;
            meas_period <= rec_period;
            meas_high   <= rec_high;
            meas_sat    <= rec_sat;
            meas_stuck  <= rec_stuck;
            meas_level  <= rec_level;
         end else if (meas_valid && meas_ready) begin
            meas_valid <= 1'b0;
         end
         if (rec_new && meas_valid && !meas_ready) begin
            meas_ovf <= 1'b1;
         end else if (clr_i) begin
            meas_ovf <= 1'b0;
         end
      end
   end

endmodule
